ddr2_ring_controller: RTL and testbench

DDR2_RING_CONTROLLER -- requirements
Module: ddr2_ring_controller

---
 rtl/ddr2_ring_controller.sv | 186 ++++++++++++++++++
 tb/tb_ddr2_ring_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_ring_controller.sv
// Ring-buffer controller for an MCB port: streams input-buffer bursts into a DDR2 ring
// and reads them back in order into the output buffer.
module ddr2_ring_controller #(
  parameter int BURST_LEN  = 32,
  parameter int RATIO      = 2,
  parameter int BASE_ADDR  = 0,
  parameter int RING_BYTES = 1 << 26,
  parameter int OB_LIMIT   = 440
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writes_en,
  input  logic                  reads_en,
  input  logic                  calib_done,
  output logic                  ib_re,
  input  logic [32*RATIO-1:0]   ib_data,
  input  logic [8:0]            ib_count,
  input  logic                  ib_valid,
  output logic                  ob_we,
  output logic [32*RATIO-1:0]   ob_data,
  input  logic [8:0]            ob_count,
  input  logic                  p0_cmd_full,
  input  logic                  p0_wr_full,
  input  logic                  p0_rd_empty,
  output logic                  p0_cmd_en,
  output logic [2:0]            p0_cmd_instr,
  output logic [29:0]           p0_cmd_byte_addr,
  output logic [5:0]            p0_cmd_bl_o,
  output logic                  p0_wr_en,
  output logic [31:0]           p0_wr_data,
  output logic [3:0]            p0_wr_mask,
  output logic                  p0_rd_en_o,
  input  logic [31:0]           p0_rd_data,
  output logic [29:0]           fill_bytes,
  output logic                  ring_full
);
  localparam int W = 32 * RATIO;
  localparam logic [29:0] BURST_B = 30'(4 * BURST_LEN);
  localparam logic [29:0] BASE    = 30'(BASE_ADDR);
  localparam logic [29:0] LAST    = 30'(BASE_ADDR + RING_BYTES - 4 * BURST_LEN);
  localparam logic [29:0] FULL_TH = 30'(RING_BYTES - 4 * BURST_LEN);
  localparam logic [8:0]  IB_ENT  = 9'(BURST_LEN / RATIO);
  localparam logic [11:0] OB_ENT  = 12'(BURST_LEN / RATIO);
  localparam logic [11:0] OB_LIM  = 12'(OB_LIMIT);
  localparam logic [2:0]  BEAT_LAST = 3'(RATIO - 1);
  localparam logic [6:0]  WORDS   = 7'(BURST_LEN);

  localparam logic [3:0] S_IDLE = 4'd0, S_WR_POP = 4'd1, S_WR_WAIT = 4'd2, S_WR_PUSH = 4'd3,
                         S_WR_CMD = 4'd4, S_RD_CMD = 4'd5, S_RD_POP = 4'd6, S_RD_CAP = 4'd7,
                         S_RD_PUSH = 4'd8, S_RD_NEXT = 4'd9;

  logic [3:0]   r_state;
  logic         r_prio_wr;
  logic [29:0]  r_wr_ptr, r_rd_ptr, r_fill, r_cmd_addr;
  logic [2:0]   r_cmd_instr, r_beat;
  logic [10:0]  r_rq;
  logic [11:0]  r_ob_used;
  logic [6:0]   r_words;
  logic [W-1:0] r_wbuf, r_rbuf, r_ob_data, w_rd_merge;
  logic         w_wr_elig, w_rd_elig, w_wr_cmd, w_rd_cmd, w_rq_dec;

  function automatic logic [29:0] f_next(input logic [29:0] p);
    return (p == LAST) ? BASE : p + BURST_B;
  endfunction

  assign ring_full  = r_fill > FULL_TH;
  assign w_wr_elig  = calib_done & writes_en & (ib_count >= IB_ENT) & ~ring_full & ~p0_cmd_full;
  assign w_rd_elig  = calib_done & reads_en & (r_fill >= BURST_B) &
                      (r_ob_used + OB_ENT <= OB_LIM) & ~p0_cmd_full;

  assign w_wr_cmd   = (r_state == S_WR_CMD) & ~p0_cmd_full;
  assign w_rd_cmd   = (r_state == S_RD_CMD) & ~p0_cmd_full;
  assign ib_re      = (r_state == S_WR_POP);
  assign p0_wr_en   = (r_state == S_WR_PUSH) & ~p0_wr_full;
  assign p0_rd_en_o = (r_state == S_RD_POP) & ~p0_rd_empty;
  assign p0_cmd_en  = w_wr_cmd | w_rd_cmd;
  assign ob_we      = (r_state == S_RD_PUSH);
  assign w_rq_dec   = ob_we & ((r_rq != 11'd0) | w_rd_cmd);

  assign p0_wr_data       = r_wbuf[31:0];
  assign ob_data          = r_ob_data;
  assign p0_cmd_instr     = r_cmd_instr;
  assign p0_cmd_byte_addr = r_cmd_addr;
  assign p0_cmd_bl_o      = 6'(BURST_LEN - 1);
  assign p0_wr_mask       = 4'd0;
  assign fill_bytes       = r_fill;

  // Word r_beat of the entry being assembled lands in its final lane.
  always_comb begin
    w_rd_merge = r_rbuf;
    w_rd_merge[{r_beat, 5'b0} +: 32] = p0_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill    <= '0;
      r_rq      <= '0;
      r_ob_used <= '0;
    end else begin
      if (w_wr_cmd)
        r_fill <= r_fill + BURST_B;
      else if (w_rd_cmd && r_fill >= BURST_B)
        r_fill <= r_fill - BURST_B;
      r_rq      <= r_rq + (w_rd_cmd ? OB_ENT[10:0] : 11'd0) - (w_rq_dec ? 11'd1 : 11'd0);
      r_ob_used <= {1'b0, r_rq} + {3'b0, ob_count};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prio_wr   <= 1'b1;
      r_wr_ptr    <= BASE;
      r_rd_ptr    <= BASE;
      r_cmd_addr  <= '0;
      r_cmd_instr <= '0;
      r_beat      <= '0;
      r_words     <= '0;
      r_wbuf      <= '0;
      r_rbuf      <= '0;
      r_ob_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Contention goes to whichever side did not win last time.
          if (w_wr_elig && (r_prio_wr || !w_rd_elig)) begin
            r_state   <= S_WR_POP;
            r_prio_wr <= 1'b0;
            r_words   <= '0;
          end else if (w_rd_elig) begin
            r_state     <= S_RD_CMD;
            r_prio_wr   <= 1'b1;
            r_cmd_instr <= 3'b001;
            r_cmd_addr  <= r_rd_ptr;
          end
        end
        S_WR_POP: r_state <= S_WR_WAIT;
        S_WR_WAIT: if (ib_valid) begin
          r_wbuf  <= ib_data;
          r_beat  <= '0;
          r_state <= S_WR_PUSH;
        end
        S_WR_PUSH: if (!p0_wr_full) begin
          r_wbuf  <= r_wbuf >> 32;
          r_beat  <= r_beat + 3'd1;
          r_words <= r_words + 7'd1;
          if (r_beat == BEAT_LAST) begin
            if (r_words == WORDS - 7'd1) begin
              r_state     <= S_WR_CMD;
              r_cmd_instr <= 3'b000;
              r_cmd_addr  <= r_wr_ptr;
            end else
              r_state <= S_WR_POP;
          end
        end
        S_WR_CMD: if (!p0_cmd_full) begin
          r_wr_ptr <= f_next(r_wr_ptr);
          r_state  <= S_IDLE;
        end
        S_RD_CMD: if (!p0_cmd_full) begin
          r_rd_ptr <= f_next(r_rd_ptr);
          r_words  <= '0;
          r_beat   <= '0;
          r_state  <= S_RD_POP;
        end
        S_RD_POP: if (!p0_rd_empty) r_state <= S_RD_CAP;
        S_RD_CAP: begin
          r_rbuf  <= w_rd_merge;
          r_beat  <= r_beat + 3'd1;
          r_words <= r_words + 7'd1;
          if (r_beat == BEAT_LAST) begin
            r_ob_data <= w_rd_merge;
            r_state   <= S_RD_PUSH;
          end else
            r_state <= S_RD_POP;
        end
        S_RD_PUSH: r_state <= S_RD_NEXT;
        S_RD_NEXT: begin
          r_beat  <= '0;
          r_state <= (r_words == WORDS) ? S_IDLE : S_RD_POP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr2_ring_controller.sv
// Directed bench: behavioural input buffer + MCB memory model, scoreboard queues for
// write beats, commands and output entries.
module tb_ddr2_ring_controller;
  localparam int BL = 32, RT = 2, RB = 512;

  logic clk = 1'b0, reset = 1'b1;
  logic writes_en = 1'b0, reads_en = 1'b0, calib_done = 1'b0;
  logic ib_re, ib_valid, ob_we;
  logic [63:0] ib_data, ob_data;
  logic [8:0] ib_count, ob_count = 9'd0;
  logic p0_cmd_full = 1'b0, p0_wr_full = 1'b0, p0_rd_empty;
  logic p0_cmd_en, p0_wr_en, p0_rd_en_o, ring_full;
  logic [2:0] p0_cmd_instr;
  logic [29:0] p0_cmd_byte_addr, fill_bytes;
  logic [5:0] p0_cmd_bl_o;
  logic [31:0] p0_wr_data, p0_rd_data;
  logic [3:0] p0_wr_mask;

  ddr2_ring_controller #(.BURST_LEN(BL), .RATIO(RT), .BASE_ADDR(0), .RING_BYTES(RB),
                         .OB_LIMIT(440)) dut (
    .clk(clk), .reset(reset), .writes_en(writes_en), .reads_en(reads_en),
    .calib_done(calib_done), .ib_re(ib_re), .ib_data(ib_data), .ib_count(ib_count),
    .ib_valid(ib_valid), .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
    .p0_cmd_full(p0_cmd_full), .p0_wr_full(p0_wr_full), .p0_rd_empty(p0_rd_empty),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_byte_addr(p0_cmd_byte_addr),
    .p0_cmd_bl_o(p0_cmd_bl_o), .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data),
    .p0_wr_mask(p0_wr_mask), .p0_rd_en_o(p0_rd_en_o), .p0_rd_data(p0_rd_data),
    .fill_bytes(fill_bytes), .ring_full(ring_full));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wr_beats = 0, rd_beats = 0, cmd_cnt = 0, ob_cnt = 0;
  logic [63:0] ibq[$], exp_ob[$];
  logic [31:0] wq[$], rq[$], exp_wr[$];
  logic [32:0] exp_cmd[$];
  logic [31:0] mem [0:127];
  int ma;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input buffer and MCB memory model.
  always @(posedge clk) begin
    if (reset) begin
      wq.delete();
      rq.delete();
      p0_rd_empty <= 1'b1;
      ib_valid    <= 1'b0;
      p0_rd_data  <= '0;
    end else begin
      if (ib_re) begin
        if (ibq.size() != 0) ib_data <= ibq.pop_front();
        else ib_data <= '0;
        ib_valid <= 1'b1;
      end else
        ib_valid <= 1'b0;
      if (p0_wr_en) wq.push_back(p0_wr_data);
      if (p0_rd_en_o && rq.size() != 0) p0_rd_data <= rq.pop_front();
      if (p0_cmd_en) begin
        ma = int'(p0_cmd_byte_addr >> 2);
        for (int i = 0; i < BL; i++) begin
          if (p0_cmd_instr == 3'b000) begin
            if (wq.size() != 0) mem[(ma + i) % 128] = wq.pop_front();
          end else
            rq.push_back(mem[(ma + i) % 128]);
        end
      end
      p0_rd_empty <= (rq.size() == 0);
    end
    ib_count <= 9'(ibq.size());
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (p0_wr_full) chk("wr_en_while_full", 64'(p0_wr_en), 64'd0);
      if (p0_wr_en) begin
        wr_beats++;
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'(p0_wr_en), 64'd0);
        else chk("wr_data", 64'(p0_wr_data), 64'(exp_wr.pop_front()));
      end
      if (p0_rd_en_o) rd_beats++;
      if (p0_cmd_en) begin
        cmd_cnt++;
        chk("cmd_bl", 64'(p0_cmd_bl_o), 64'd31);
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 64'(p0_cmd_en), 64'd0);
        else chk("cmd", 64'({p0_cmd_instr, p0_cmd_byte_addr}), 64'(exp_cmd.pop_front()));
      end
      if (ob_we) begin
        ob_cnt++;
        if (exp_ob.size() == 0) chk("ob_unexpected", 64'(ob_we), 64'd0);
        else chk("ob_data", ob_data, exp_ob.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int probe(input int w);
    case (w)
      0: return int'(fill_bytes);
      1: return ob_cnt;
      2: return wr_beats;
      3: return rd_beats;
      default: return cmd_cnt;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input int v);
    int n = 0;
    while (probe(w) < v && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 64'(probe(w)), 64'(v));
  endtask

  task automatic push_ib(input int n);
    logic [63:0] e;
    for (int k = 0; k < n; k++) begin
      e = {$urandom, $urandom};
      ibq.push_back(e);
      exp_wr.push_back(e[31:0]);
      exp_wr.push_back(e[63:32]);
      exp_ob.push_back(e);
    end
  endtask

  task automatic cmd_exp(input logic [2:0] instr, input int addr);
    exp_cmd.push_back({instr, 30'(addr)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    ibq.delete(); exp_ob.delete(); exp_wr.delete(); exp_cmd.delete();
  endtask

  int base, obb, rb;

  initial begin
    do_reset();
    chk("rst_strobes", 64'({ib_re, ob_we, p0_cmd_en, p0_wr_en, p0_rd_en_o}), 64'd0);
    chk("rst_fill", 64'(fill_bytes), 64'd0);
    chk("rst_ring_full", 64'(ring_full), 64'd0);
    chk("rst_cmd", 64'({p0_cmd_instr, p0_cmd_byte_addr}), 64'd0);
    chk("rst_ob_data", ob_data, 64'd0);
    chk("rst_wr_data", 64'(p0_wr_data), 64'd0);
    chk("rst_mask_bl", 64'({p0_wr_mask, p0_cmd_bl_o}), 64'd31);

    calib_done = 1'b1;
    reads_en = 1'b1;
    repeat (20) step();
    chk("rd_empty_no_cmd", 64'(cmd_cnt), 64'd0);
    reads_en = 1'b0;

    push_ib(16);
    cmd_exp(3'b000, 0);
    writes_en = 1'b1;
    wait_for("wr1_fill", 0, 128);
    chk("wr1_beats", 64'(wr_beats), 64'd32);
    writes_en = 1'b0;
    cmd_exp(3'b001, 0);
    reads_en = 1'b1;
    wait_for("rd1_ob", 1, 16);
    reads_en = 1'b0;
    chk("rd1_fill", 64'(fill_bytes), 64'd0);

    push_ib(16);
    cmd_exp(3'b000, 128);
    writes_en = 1'b1;
    wait_for("stall_start", 2, 42);
    p0_wr_full = 1'b1;
    repeat (5) step();
    p0_wr_full = 1'b0;
    chk("stall_beats", 64'(wr_beats), 64'd42);
    wait_for("stall_fill", 0, 128);
    chk("stall_total", 64'(wr_beats), 64'd64);
    writes_en = 1'b0;
    cmd_exp(3'b001, 128);
    reads_en = 1'b1;
    wait_for("rd2_ob", 1, 32);
    reads_en = 1'b0;
    chk("rd2_fill", 64'(fill_bytes), 64'd0);

    do_reset();
    push_ib(64);
    for (int k = 0; k < 4; k++) cmd_exp(3'b000, k * 128);
    writes_en = 1'b1;
    wait_for("ring_fill", 0, 512);
    chk("ring_full_set", 64'(ring_full), 64'd1);
    base = cmd_cnt;
    push_ib(16);
    repeat (40) step();
    chk("ring_stall_fill", 64'(fill_bytes), 64'd512);
    chk("ring_stall_cmds", 64'(cmd_cnt), 64'(base));
    cmd_exp(3'b001, 0);
    cmd_exp(3'b000, 0);
    obb = ob_cnt;
    reads_en = 1'b1;
    wait_for("ring_rd_cmd", 4, base + 1);
    reads_en = 1'b0;
    wait_for("ring_rd_ob", 1, obb + 16);
    wait_for("ring_wrap_cmd", 4, base + 2);
    chk("ring_refill", 64'(fill_bytes), 64'd512);
    chk("ring_cmd_q", 64'(exp_cmd.size()), 64'd0);
    writes_en = 1'b0;

    do_reset();
    push_ib(48);
    cmd_exp(3'b000, 0);   cmd_exp(3'b001, 0);
    cmd_exp(3'b000, 128); cmd_exp(3'b001, 128);
    cmd_exp(3'b000, 256); cmd_exp(3'b001, 256);
    base = cmd_cnt;
    obb = ob_cnt;
    writes_en = 1'b1;
    reads_en = 1'b1;
    wait_for("alt_cmds", 4, base + 6);
    wait_for("alt_ob", 1, obb + 48);
    writes_en = 1'b0;
    reads_en = 1'b0;
    chk("alt_cmd_q", 64'(exp_cmd.size()), 64'd0);

    push_ib(32);
    cmd_exp(3'b000, 384);
    cmd_exp(3'b000, 0);
    writes_en = 1'b1;
    wait_for("pre_rst_fill", 0, 256);
    writes_en = 1'b0;
    cmd_exp(3'b001, 384);
    rb = rd_beats;
    reads_en = 1'b1;
    wait_for("rd_beat10", 3, rb + 10);
    reset = 1'b1;
    step();
    chk("abort_strobes", 64'({ib_re, ob_we, p0_cmd_en, p0_wr_en, p0_rd_en_o}), 64'd0);
    chk("abort_fill", 64'(fill_bytes), 64'd0);
    chk("abort_cmd_q", 64'(exp_cmd.size()), 64'd0);
    reads_en = 1'b0;
    step();
    reset = 1'b0;
    ibq.delete(); exp_ob.delete(); exp_wr.delete();
    step();
    chk("abort_idle", 64'({ib_re, ob_we, p0_cmd_en, p0_wr_en, p0_rd_en_o}), 64'd0);

    push_ib(16);
    cmd_exp(3'b000, 0);
    writes_en = 1'b1;
    wait_for("post_rst_fill", 0, 128);
    writes_en = 1'b0;
    cmd_exp(3'b001, 0);
    obb = ob_cnt;
    reads_en = 1'b1;
    wait_for("post_rst_ob", 1, obb + 16);
    reads_en = 1'b0;
    chk("post_rst_drain", 64'(fill_bytes), 64'd0);
    chk("post_rst_cmd_q", 64'(exp_cmd.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
